// File: rtl/morse_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_rx_decoder
// Purpose  : Samples a Morse on/off line once per unit tick, classifies
//            dots/dashes and gaps, and decodes ITU A-Z into a letter history.
// Revision : 1.0 - initial release
// ============================================================================
module morse_rx_decoder #(
    parameter int DASH_MIN   = 3,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic        wiCLK,
    input  logic        wrst,
    input  logic        wTick,
    input  logic        wLine,
    input  logic        wClr,
    output logic [4:0]  wLetter,
    output logic        wValid,
    output logic        wErr,
    output logic        wSpace,
    output logic [14:0] wHist,
    output logic        wBusy
);
    localparam logic [3:0] c_DASH_MIN   = 4'(DASH_MIN);
    localparam logic [3:0] c_LETTER_GAP = 4'(LETTER_GAP);
    localparam logic [3:0] c_WORD_GAP   = 4'(WORD_GAP);
    localparam logic [4:0] c_NONE       = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_run;
    logic [3:0] r_sym;
    logic [2:0] r_len;
    logic       r_ovf;

    logic [3:0] w_run_inc;
    logic       w_dash;
    logic [4:0] w_code;

    // Element k lives in sym[k], dash = 1; unused upper bits are always 0.
    function automatic logic [4:0] decode(input logic [2:0] len, input logic [3:0] sym);
        case ({len, sym})
            {3'd2, 4'd2}:  decode = 5'd0;   // A .-
            {3'd4, 4'd1}:  decode = 5'd1;   // B -...
            {3'd4, 4'd5}:  decode = 5'd2;   // C -.-.
            {3'd3, 4'd1}:  decode = 5'd3;   // D -..
            {3'd1, 4'd0}:  decode = 5'd4;   // E .
            {3'd4, 4'd4}:  decode = 5'd5;   // F ..-.
            {3'd3, 4'd3}:  decode = 5'd6;   // G --.
            {3'd4, 4'd0}:  decode = 5'd7;   // H ....
            {3'd2, 4'd0}:  decode = 5'd8;   // I ..
            {3'd4, 4'd14}: decode = 5'd9;   // J .---
            {3'd3, 4'd5}:  decode = 5'd10;  // K -.-
            {3'd4, 4'd2}:  decode = 5'd11;  // L .-..
            {3'd2, 4'd3}:  decode = 5'd12;  // M --
            {3'd2, 4'd1}:  decode = 5'd13;  // N -.
            {3'd3, 4'd7}:  decode = 5'd14;  // O ---
            {3'd4, 4'd6}:  decode = 5'd15;  // P .--.
            {3'd4, 4'd11}: decode = 5'd16;  // Q --.-
            {3'd3, 4'd2}:  decode = 5'd17;  // R .-.
            {3'd3, 4'd0}:  decode = 5'd18;  // S ...
            {3'd1, 4'd1}:  decode = 5'd19;  // T -
            {3'd3, 4'd4}:  decode = 5'd20;  // U ..-
            {3'd4, 4'd8}:  decode = 5'd21;  // V ...-
            {3'd3, 4'd6}:  decode = 5'd22;  // W .--
            {3'd4, 4'd9}:  decode = 5'd23;  // X -..-
            {3'd4, 4'd13}: decode = 5'd24;  // Y -.--
            {3'd4, 4'd3}:  decode = 5'd25;  // Z --..
            default:       decode = c_NONE;
        endcase
    endfunction

    assign w_run_inc = (r_run == 4'hF) ? 4'hF : r_run + 4'd1;
    assign w_dash    = (r_run >= c_DASH_MIN);
    assign w_code    = decode(r_len, r_sym);
    assign wBusy     = (r_state != S_IDLE);

    always_ff @(posedge wiCLK or negedge wrst) begin
        if (!wrst) begin
            r_state <= S_IDLE;
            r_run   <= 4'd0;
            r_sym   <= 4'd0;
            r_len   <= 3'd0;
            r_ovf   <= 1'b0;
            wLetter <= c_NONE;
            wValid  <= 1'b0;
            wErr    <= 1'b0;
            wSpace  <= 1'b0;
            wHist   <= 15'h7FFF;
        end else begin
            wValid <= 1'b0;
            wErr   <= 1'b0;
            wSpace <= 1'b0;
            if (wClr) begin
                r_state <= S_IDLE;
                r_run   <= 4'd0;
                r_sym   <= 4'd0;
                r_len   <= 3'd0;
                r_ovf   <= 1'b0;
                wLetter <= c_NONE;
                wHist   <= 15'h7FFF;
            end else if (wTick) begin
                case (r_state)
                    S_IDLE: begin
                        if (wLine) begin
                            r_state <= S_MARK;
                            r_run   <= 4'd1;
                        end
                    end
                    S_MARK: begin
                        if (wLine) begin
                            r_run <= w_run_inc;
                        end else begin
                            if (r_len < 3'd4) begin
                                r_sym[r_len[1:0]] <= w_dash;
                                r_len             <= r_len + 3'd1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                            r_state <= S_SPACE;
                            r_run   <= 4'd1;
                        end
                    end
                    S_SPACE: begin
                        if (wLine) begin
                            r_state <= S_MARK;
                            r_run   <= 4'd1;
                        end else begin
                            r_run <= w_run_inc;
                            if (w_run_inc >= c_LETTER_GAP) begin
                                if (!r_ovf && (w_code != c_NONE)) begin
                                    wLetter <= w_code;
                                    wValid  <= 1'b1;
                                    wHist   <= {wHist[9:0], w_code};
                                end else begin
                                    wLetter <= c_NONE;
                                    wErr    <= 1'b1;
                                end
                                r_sym   <= 4'd0;
                                r_len   <= 3'd0;
                                r_ovf   <= 1'b0;
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (wLine) begin
                            r_state <= S_MARK;
                            r_run   <= 4'd1;
                        end else begin
                            r_run <= w_run_inc;
                            if (w_run_inc >= c_WORD_GAP) begin
                                wSpace  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_rx_decoder
// Purpose  : Self-checking bench for morse_rx_decoder, directed scenarios plus
//            random letters checked against a string-table Morse model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_rx_decoder;
    localparam int DASH_MIN   = 3;
    localparam int LETTER_GAP = 3;
    localparam int WORD_GAP   = 7;

    logic        wiCLK = 1'b0;
    logic        wrst  = 1'b0;
    logic        wTick = 1'b0;
    logic        wLine = 1'b0;
    logic        wClr  = 1'b0;
    logic [4:0]  wLetter;
    logic        wValid;
    logic        wErr;
    logic        wSpace;
    logic [14:0] wHist;
    logic        wBusy;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_v = 0;
    int cnt_e = 0;
    int cnt_s = 0;
    logic [14:0] exp_hist = 15'h7FFF;

    string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

    morse_rx_decoder #(
        .DASH_MIN   (DASH_MIN),
        .LETTER_GAP (LETTER_GAP),
        .WORD_GAP   (WORD_GAP)
    ) dut (
        .wiCLK   (wiCLK),
        .wrst    (wrst),
        .wTick   (wTick),
        .wLine   (wLine),
        .wClr    (wClr),
        .wLetter (wLetter),
        .wValid  (wValid),
        .wErr    (wErr),
        .wSpace  (wSpace),
        .wHist   (wHist),
        .wBusy   (wBusy)
    );

    always #5 wiCLK = ~wiCLK;

    function automatic int lookup(input string p);
        for (int i = 0; i < 26; i++)
            if (MORSE[i] == p) return i;
        return 31;
    endfunction

    // One tick cycle; returns at the following falling edge with its result visible.
    task automatic tick(input logic line, input logic clr);
        @(negedge wiCLK);
        wLine = line;
        wTick = 1'b1;
        wClr  = clr;
        @(negedge wiCLK);
        wTick = 1'b0;
        wClr  = 1'b0;
        cnt_v += int'(wValid);
        cnt_e += int'(wErr);
        cnt_s += int'(wSpace);
    endtask

    task automatic clear_counts();
        cnt_v = 0;
        cnt_e = 0;
        cnt_s = 0;
    endtask

    task automatic do_clear();
        @(negedge wiCLK);
        wClr = 1'b1;
        @(negedge wiCLK);
        wClr = 1'b0;
        exp_hist = 15'h7FFF;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) tick(bits[i], 1'b0);
    endtask

    task automatic send_pattern(input string pat);
        int mlen;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "-")
                mlen = ($urandom_range(7) == 0) ? 18 : int'($urandom_range(DASH_MIN + 3, DASH_MIN));
            else
                mlen = int'($urandom_range(DASH_MIN - 1, 1));
            repeat (mlen) tick(1'b1, 1'b0);
            if (i != pat.len() - 1)
                repeat (int'($urandom_range(LETTER_GAP - 1, 1))) tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge wiCLK);
        wrst = 1'b1;
        @(negedge wiCLK);
        n_cmp++; if (wHist !== 15'h7FFF) begin n_bad++; $display("FAIL rst_hist: got %h want 7fff", wHist); end
        n_cmp++; if (wLetter !== 5'd31) begin n_bad++; $display("FAIL rst_letter: got %0d want 31", wLetter); end
        n_cmp++; if ({wValid, wErr, wSpace, wBusy} !== 4'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {wValid, wErr, wSpace, wBusy}); end
        send_bits(32'b101, 3);
        n_cmp++; if (wBusy !== 1'b1) begin n_bad++; $display("FAIL rst_busy_mid: got %b want 1", wBusy); end
        #2 wrst = 1'b0;
        #1;
        n_cmp++; if ({wHist, wLetter, wValid, wErr, wSpace, wBusy} !== {15'h7FFF, 5'd31, 4'b0}) begin
            n_bad++; $display("FAIL rst_async: got hist=%h letter=%0d flags=%b want 7fff/31/0000",
                              wHist, wLetter, {wValid, wErr, wSpace, wBusy});
        end
        @(negedge wiCLK);
        wrst = 1'b1;
        clear_counts();
        send_bits(32'b1000, 4);
        n_cmp++; if (wValid !== 1'b1 || wLetter !== 5'd4 || cnt_v != 1) begin
            n_bad++; $display("FAIL rst_lost_partial: got valid=%b letter=%0d want 1/4", wValid, wLetter);
        end
    endtask

    task automatic test_letter_a();
        do_clear();
        clear_counts();
        send_bits(32'b1011100, 7);
        n_cmp++; if (cnt_v + cnt_e + cnt_s != 0) begin n_bad++; $display("FAIL a_early: got %0d pulses want 0", cnt_v + cnt_e + cnt_s); end
        tick(1'b0, 1'b0);
        n_cmp++; if (wValid !== 1'b1 || wErr !== 1'b0) begin n_bad++; $display("FAIL a_valid: got v=%b e=%b want 1/0", wValid, wErr); end
        n_cmp++; if (wLetter !== 5'd0) begin n_bad++; $display("FAIL a_letter: got %0d want 0", wLetter); end
        n_cmp++; if (wHist !== 15'h7FE0) begin n_bad++; $display("FAIL a_hist: got %h want 7fe0", wHist); end
        @(negedge wiCLK);
        n_cmp++; if (wValid !== 1'b0) begin n_bad++; $display("FAIL a_pulse_width: got %b want 0", wValid); end
    endtask

    task automatic test_dash_boundary();
        do_clear();
        send_bits(32'b11000, 5);
        n_cmp++; if (wValid !== 1'b1 || wLetter !== 5'd4) begin n_bad++; $display("FAIL dot_len2: got v=%b letter=%0d want 1/4", wValid, wLetter); end
        send_bits(32'b111000, 6);
        n_cmp++; if (wValid !== 1'b1 || wLetter !== 5'd19) begin n_bad++; $display("FAIL dash_len3: got v=%b letter=%0d want 1/19", wValid, wLetter); end
        n_cmp++; if (wHist !== 15'h7C93) begin n_bad++; $display("FAIL dash_hist: got %h want 7c93", wHist); end
    endtask

    task automatic test_errors();
        clear_counts();
        send_bits(32'b101010101000, 12);
        n_cmp++; if (wErr !== 1'b1 || wValid !== 1'b0 || cnt_e != 1) begin n_bad++; $display("FAIL err_overflow: got e=%b v=%b want 1/0", wErr, wValid); end
        n_cmp++; if (wLetter !== 5'd31 || wHist !== 15'h7C93) begin n_bad++; $display("FAIL err_ovf_out: got letter=%0d hist=%h want 31/7c93", wLetter, wHist); end
        send_bits(32'b10111010111000, 14);
        n_cmp++; if (wErr !== 1'b1 || wValid !== 1'b0 || wLetter !== 5'd31) begin
            n_bad++; $display("FAIL err_pattern: got e=%b v=%b letter=%0d want 1/0/31", wErr, wValid, wLetter);
        end
        n_cmp++; if (wHist !== 15'h7C93) begin n_bad++; $display("FAIL err_hist: got %h want 7c93", wHist); end
    endtask

    task automatic test_word_gap();
        do_clear();
        send_bits(32'b1000, 4);
        clear_counts();
        send_bits(32'b000, 3);
        n_cmp++; if (cnt_s != 0 || wBusy !== 1'b1) begin n_bad++; $display("FAIL wg_early: got spaces=%0d busy=%b want 0/1", cnt_s, wBusy); end
        tick(1'b0, 1'b0);
        n_cmp++; if (wSpace !== 1'b1 || wBusy !== 1'b0) begin n_bad++; $display("FAIL wg_space: got s=%b busy=%b want 1/0", wSpace, wBusy); end
        clear_counts();
        send_bits(32'b00000, 5);
        n_cmp++; if (cnt_v + cnt_e + cnt_s != 0 || wBusy !== 1'b0) begin
            n_bad++; $display("FAIL wg_idle: got pulses=%0d busy=%b want 0/0", cnt_v + cnt_e + cnt_s, wBusy);
        end
    endtask

    task automatic test_gating();
        do_clear();
        tick(1'b1, 1'b0);
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            @(negedge wiCLK);
            wLine = ~wLine;
        end
        @(negedge wiCLK);
        n_cmp++; if (wBusy !== 1'b1 || wValid !== 1'b0 || wErr !== 1'b0) begin n_bad++; $display("FAIL gate_hold: got busy=%b v=%b e=%b want 1/0/0", wBusy, wValid, wErr); end
        send_bits(32'b000, 3);
        n_cmp++; if (wValid !== 1'b1 || wLetter !== 5'd4 || wHist !== 15'h7FE4) begin
            n_bad++; $display("FAIL gate_letter: got v=%b letter=%0d hist=%h want 1/4/7fe4", wValid, wLetter, wHist);
        end
    endtask

    task automatic test_clear();
        do_clear();
        send_bits(32'b1000, 4);
        send_bits(32'b11, 2);
        @(negedge wiCLK);
        wClr = 1'b1;
        @(negedge wiCLK);
        wClr = 1'b0;
        n_cmp++; if (wBusy !== 1'b0 || wHist !== 15'h7FFF || wLetter !== 5'd31) begin
            n_bad++; $display("FAIL clr_mark: got busy=%b hist=%h letter=%0d want 0/7fff/31", wBusy, wHist, wLetter);
        end
        send_bits(32'b1000, 4);
        send_bits(32'b100, 3);
        clear_counts();
        tick(1'b0, 1'b1);
        n_cmp++; if (wValid !== 1'b0 || wErr !== 1'b0 || wHist !== 15'h7FFF || wLetter !== 5'd31 || wBusy !== 1'b0) begin
            n_bad++; $display("FAIL clr_vs_decode: got v=%b e=%b hist=%h letter=%0d busy=%b want 0/0/7fff/31/0",
                              wValid, wErr, wHist, wLetter, wBusy);
        end
        send_bits(32'b0000000000, 10);
        n_cmp++; if (cnt_v + cnt_e + cnt_s != 0) begin n_bad++; $display("FAIL clr_after: got %0d pulses want 0", cnt_v + cnt_e + cnt_s); end
    endtask

    task automatic test_random();
        string pat;
        int    idx;
        int    plen;
        int    extra;
        int    lows;
        do_clear();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(9) < 7) begin
                pat = MORSE[$urandom_range(25)];
            end else begin
                pat  = "";
                plen = int'($urandom_range(6, 1));
                for (int k = 0; k < plen; k++) pat = {pat, ($urandom_range(1) == 1) ? "-" : "."};
            end
            idx = lookup(pat);
            clear_counts();
            send_pattern(pat);
            repeat (LETTER_GAP - 1) tick(1'b0, 1'b0);
            n_cmp++; if (cnt_v + cnt_e + cnt_s != 0) begin n_bad++; $display("FAIL rnd_stray[%0d] %s: got %0d pulses want 0", n, pat, cnt_v + cnt_e + cnt_s); end
            tick(1'b0, 1'b0);
            if (idx != 31) exp_hist = {exp_hist[9:0], 5'(idx)};
            n_cmp++; if (wValid !== (idx != 31) || wErr !== (idx == 31)) begin
                n_bad++; $display("FAIL rnd_pulse[%0d] %s: got v=%b e=%b want v=%b", n, pat, wValid, wErr, idx != 31);
            end
            n_cmp++; if (wLetter !== 5'(idx)) begin n_bad++; $display("FAIL rnd_letter[%0d] %s: got %0d want %0d", n, pat, wLetter, idx); end
            n_cmp++; if (wHist !== exp_hist) begin n_bad++; $display("FAIL rnd_hist[%0d] %s: got %h want %h", n, pat, wHist, exp_hist); end
            extra = int'($urandom_range(6));
            clear_counts();
            repeat (extra) tick(1'b0, 1'b0);
            lows = LETTER_GAP + extra;
            n_cmp++; if (cnt_s != ((lows >= WORD_GAP) ? 1 : 0) || cnt_v + cnt_e != 0) begin
                n_bad++; $display("FAIL rnd_gap[%0d]: got spaces=%0d other=%0d after %0d lows", n, cnt_s, cnt_v + cnt_e, lows);
            end
            n_cmp++; if (wBusy !== (lows < WORD_GAP)) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, wBusy, lows < WORD_GAP); end
        end
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_dash_boundary();
        test_errors();
        test_word_gap();
        test_gating();
        test_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_rx_decoder.md
Name: morse_rx_decoder

Overview:
- Receive-side companion to the Morse transmitter; sits directly downstream of the TX lamp output (or an external key line).
- Samples a serial on/off Morse line once per unit tick and classifies mark runs as dot or dash.
- Detects letter and word gaps, decodes ITU Morse A–Z to a 5-bit letter index (0 = A … 25 = Z).
- Keeps a 3-letter rolling history in the same 15-bit format as the TX letter history, for the existing 7-segment path.

Parameters:
- DASH_MIN, 3: minimum mark run (ticks) classified as a dash; shorter runs are dots.
- LETTER_GAP, 3: space run (ticks) that terminates a letter.
- WORD_GAP, 7: space run (ticks) that flags a word gap. Constraint: 1 < LETTER_GAP < WORD_GAP ≤ 15.

Ports:
- wiCLK  in  1  system clock
- wrst  in  1  asynchronous, active-low reset
- wTick  in  1  one-cycle unit-time sample enable (half-second strobe)
- wLine  in  1  Morse line, synchronous to wiCLK, 1 = mark
- wClr  in  1  synchronous clear of FSM, symbol and history
- wLetter  out  5  last decoded letter index; 5'd31 = none/error
- wValid  out  1  one-cycle pulse: wLetter updated with a valid letter
- wErr  out  1  one-cycle pulse: undecodable symbol
- wSpace  out  1  one-cycle pulse: word gap detected
- wHist  out  15  {older, middle, newest} letter history
- wBusy  out  1  high whenever FSM ≠ IDLE

Behaviour:
- Reset: async on wrst low. Reset values: wLetter = 31, wValid = wErr = wSpace = 0, wHist = 15'h7FFF, FSM = IDLE, run = 0, len = 0, sym = 0.
- Sampling: wLine is evaluated only in cycles with wTick = 1; all other cycles hold state. Pulse outputs are registered, asserted the cycle after the deciding tick, and held for exactly one cycle.
- Run counter: 4 bits, saturates at 15.
- Symbol store: sym[3:0] plus len[2:0]. Element k is stored at sym[k] (first element at bit 0); dash = 1, dot = 0.
- State IDLE:
  - line 1 → MARK, run = 1.
  - line 0 → stay.
- State MARK:
  - line 1 → run++.
  - line 0 → classify: run ≥ DASH_MIN → dash, else dot.
    - If len < 4: store the element at sym[len], len++.
    - If len = 4: set overflow flag.
    - Go to SPACE, run = 1.
- State SPACE:
  - line 1 → MARK, run = 1 (intra-letter gap).
  - line 0 → run++.
  - When run reaches LETTER_GAP: decode, then go to GAP. Decode outcomes:
    - Valid letter: wLetter = index, wValid pulse, wHist = {wHist[9:0], index}.
    - Overflow or pattern not in A–Z: wLetter = 31, wErr pulse, wHist unchanged.
  - Then clear sym, len and the overflow flag.
- State GAP:
  - line 1 → MARK, run = 1.
  - line 0 → run++ (run continues from LETTER_GAP).
  - When run reaches WORD_GAP: wSpace pulse, go to IDLE.
- Decode table: standard ITU A–Z, lengths 1–4. Examples: E = sym 0, len 1 → 4; T = sym 1, len 1 → 19; A = sym 2'b10, len 2 → 0; Q (--.-) = sym 4'b1011, len 4 → 16.
- wClr: has priority over wTick. Next cycle: FSM = IDLE, sym/len/overflow cleared, wHist = 7FFF, wLetter = 31, no pulses. A partial letter is discarded silently.
- Reset mid-letter: partial symbol is lost; no pulse is emitted.
- Simultaneous letter completion and wClr: wClr wins, no wValid.
- wBusy: combinational from the FSM state.
- Latency: last gap tick to wValid/wErr = 1 cycle.

Test Plan:
- Reset: assert wrst = 0 mid-run → next cycle wHist = 7FFF, wLetter = 31, all pulses 0, wBusy = 0.
- "A": ticks 1,0,1,1,1,0,0,0 → one cycle after the 8th tick, wValid = 1 for 1 cycle, wLetter = 0, wHist = 15'h7FE0.
- Dash boundary: 1,1,0,0,0 → wLetter = 4 (E). Then 1,1,1,0,0,0 → wLetter = 19 (T), wHist = {31, 4, 19} = 15'h7C93.
- Errors:
  - Five dots (1,0 ×5), then 0,0 → wErr pulse, wLetter = 31, wHist unchanged.
  - .-.- → wErr.
- Word gap: after "E" continue 4 more low ticks (run = 7) → single wSpace pulse, FSM IDLE, wBusy = 0. Further lows → no pulses.
- Sampling gating and clear:
  - Toggle wLine on non-tick cycles → no state change.
  - Assert wClr mid-MARK → IDLE, wHist = 7FFF, no wValid even if the gap completes on that tick.
